// File: rtl/spi_flash_selftest.sv
// spi_flash_selftest: SPI NOR bring-up test (RDID, WREN, PP, POLL, READ); C/S/DQio drive the flash, LED[0]=done, LED[1]=pass
module spi_flash_selftest #(
  parameter int          SCK_DIV = 4,
  parameter int          NBYTES  = 16,
  parameter logic [23:0] ADDR    = 24'h000000,
  parameter logic [23:0] EXP_ID  = 24'h20BA18
) (
  input  logic       CLK_100M,
  input  logic       RESET,
  output logic       C,
  output logic       S,
  inout  wire  [3:0] DQio,
  output logic [1:0] LED
);
  typedef enum logic [2:0] {IDLE, RDID, WREN, PP, POLL, READ, DONE, FAIL} st_t;
  typedef enum logic [1:0] {GAP, XFER, TAIL} sub_t;
  st_t        st_q, nxt;
  sub_t       sub_q;
  logic       busy_q, c_q, done_q, s_q, pend_q, err_q;
  logic [7:0] cnt_q, sh_q, rx_q, dly_q;
  logic [2:0] bit_q;
  logic [8:0] idx_q;
  logic [1:0] led_q;
  logic       start, last, bad;
  logic [7:0] tx, cmd, ab, idb, pi, pat;
  assign C       = c_q;
  assign S       = s_q;
  assign LED     = led_q;
  assign DQio[0] = sh_q[7];
  assign DQio[1] = 1'bz;
  assign DQio[2] = 1'b1;
  assign DQio[3] = 1'b1;
  assign start = sub_q == XFER && !pend_q && !busy_q;
  assign pi    = idx_q[7:0] - 8'd4;
  assign pat   = pi * 8'h11 + 8'h5A;
  assign cmd   = st_q == RDID ? 8'h9F : st_q == WREN ? 8'h06 : st_q == PP ? 8'h02 : st_q == POLL ? 8'h05 : 8'h03;
  assign ab    = idx_q[1:0] == 2'd1 ? ADDR[23:16] : idx_q[1:0] == 2'd2 ? ADDR[15:8] : ADDR[7:0];
  assign idb   = idx_q[1:0] == 2'd1 ? EXP_ID[23:16] : idx_q[1:0] == 2'd2 ? EXP_ID[15:8] : EXP_ID[7:0];
  assign tx    = idx_q == 9'd0 ? cmd
               : (st_q == PP || st_q == READ) && idx_q < 9'd4 ? ab
               : st_q == PP ? pat : 8'h00;
  assign last  = st_q == RDID ? idx_q == 9'd3
               : st_q == WREN ? 1'b1
               : st_q == POLL ? idx_q != 9'd0 && !rx_q[0]
               : idx_q == 9'(NBYTES + 3);
  assign nxt   = st_q == RDID ? (err_q ? FAIL : WREN)
               : st_q == WREN ? PP
               : st_q == PP ? POLL
               : st_q == POLL ? READ : DONE;
  assign bad   = (st_q == RDID && idx_q != 9'd0 && rx_q != idb) ||
                 (st_q == READ && idx_q >= 9'd4 && rx_q != pat);
  always_ff @(posedge CLK_100M)
    if (RESET) begin
      busy_q <= 1'b0;
      c_q    <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      sh_q   <= '0;
      rx_q   <= '0;
      bit_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (start) begin
          busy_q <= 1'b1;
          sh_q   <= tx;
          cnt_q  <= '0;
          bit_q  <= '0;
        end
      end else begin
        cnt_q <= cnt_q == 8'(SCK_DIV - 1) ? 8'd0 : cnt_q + 8'd1;
        if (cnt_q == 8'(SCK_DIV / 2 - 1)) begin
          c_q  <= 1'b1;
          rx_q <= {rx_q[6:0], DQio[1]};
        end
        if (cnt_q == 8'(SCK_DIV - 1)) begin
          c_q   <= 1'b0;
          sh_q  <= {sh_q[6:0], 1'b0};
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
      end
    end
  always_ff @(posedge CLK_100M)
    if (RESET) begin
      st_q   <= IDLE;
      sub_q  <= GAP;
      s_q    <= 1'b1;
      led_q  <= 2'b00;
      idx_q  <= '0;
      dly_q  <= '0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (st_q == IDLE) begin
      st_q  <= RDID;
      sub_q <= XFER;
      s_q   <= 1'b0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else if (st_q == DONE || st_q == FAIL) begin
      led_q <= {st_q == DONE && !err_q, 1'b1};
    end else if (sub_q == GAP) begin
      dly_q <= dly_q + 8'd1;
      if (dly_q == 8'(2 * SCK_DIV - 1)) begin
        sub_q <= XFER;
        s_q   <= 1'b0;
        dly_q <= '0;
      end
    end else if (sub_q == XFER) begin
      if (start) pend_q <= 1'b1;
      if (done_q) begin
        pend_q <= 1'b0;
        idx_q  <= st_q == POLL ? 9'd1 : idx_q + 9'd1;
        if (bad) err_q <= 1'b1;
        if (last) sub_q <= TAIL;
      end
    end else begin
      dly_q <= dly_q + 8'd1;
      if (dly_q == 8'(SCK_DIV / 2 - 1)) begin
        s_q   <= 1'b1;
        dly_q <= '0;
        sub_q <= GAP;
        idx_q <= '0;
        st_q  <= nxt;
      end
    end
endmodule

// File: tb/tb_spi_flash_selftest.sv
// tb_spi_flash_selftest: directed bench with a behavioural N25Q model on the SPI pins
module tb_spi_flash_selftest;
  logic clk = 1'b0, rst = 1'b1, miso = 1'b0;
  wire C, S;
  wire [3:0] dq;
  wire [1:0] LED;
  assign dq[1] = miso;
  always #5 clk = ~clk;
  spi_flash_selftest dut (.CLK_100M(clk), .RESET(rst), .C(C), .S(S), .DQio(dq), .LED(LED));
  int checks = 0, errors = 0;
  logic [23:0] id = 24'h20BA18, ad = '0;
  logic [7:0] mem [0:255];
  logic [7:0] fb [0:15][0:23];
  logic [7:0] fop [0:15];
  int fp [0:15];
  int nf = 0, bc = 0, cur_p = 0, wip = 0;
  logic wel = 1'b0, open = 1'b0;
  logic [7:0] sh = '0, op = '0;
  function automatic logic [7:0] resp(int k);
    if (op == 8'h9F) return k == 1 ? id[23:16] : k == 2 ? id[15:8] : k == 3 ? id[7:0] : 8'h00;
    if (op == 8'h05) return {7'b0, wip != 0};
    if (op == 8'h03 && k >= 4) return mem[8'(ad + 24'(k - 4))];
    return 8'h00;
  endfunction
  always @(negedge S) begin
    open = 1'b1; bc = 0; cur_p = 0; op = 8'h00;
  end
  always @(posedge S) if (open) begin
    open = 1'b0;
    if (nf < 16) begin fp[nf] = cur_p; fop[nf] = op; end
    nf++;
    if (op == 8'h06) wel = 1'b1;
    else if (op == 8'h02 && wel) begin wel = 1'b0; wip = 2; end
  end
  always @(posedge C) if (open) begin
    int k;
    sh = {sh[6:0], dq[0]}; bc++; cur_p++;
    if (bc % 8 == 0) begin
      k = bc / 8 - 1;
      if (k < 24 && nf < 16) fb[nf][k] = sh;
      if (k == 0) op = sh;
      else if (k <= 3) ad = {ad[15:0], sh};
      if (op == 8'h02 && k >= 4 && wel) mem[8'(ad + 24'(k - 4))] = mem[8'(ad + 24'(k - 4))] & sh;
      if (op == 8'h05 && k >= 1 && wip > 0) wip--;
    end
  end
  always @(negedge C) if (open) begin
    logic [7:0] b;
    b = resp(bc / 8);
    miso = b[7 - bc % 8];
  end
  task automatic model_reset(input logic [23:0] new_id);
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    nf = 0; wel = 1'b0; wip = 0; id = new_id;
  endtask
  task automatic wait_nf(input int want, output bit ok);
    int t = 0;
    while (nf < want && t < 20000) begin @(negedge clk); t++; end
    ok = nf >= want;
  endtask
  task automatic wait_led(output bit ok);
    int t = 0;
    while (LED[0] !== 1'b1 && t < 20000) begin @(negedge clk); t++; end
    ok = LED[0] === 1'b1;
  endtask
  task automatic release_rst();
    @(negedge clk); rst = 1'b0;
  endtask
  task automatic test_reset();
    int bad = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset(24'h20BA18);
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (S !== 1'b1 || LED !== 2'b00) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL reset_hold bad_cycles=%0d required=0", bad); end
    checks++; if (C !== 1'b0) begin errors++; $display("FAIL reset_c got=%b required=0", C); end
    checks++; if (dq[0] !== 1'b0) begin errors++; $display("FAIL reset_mosi got=%b required=0", dq[0]); end
    checks++; if (dq[3:2] !== 2'b11) begin errors++; $display("FAIL reset_wp_hold got=%b required=11", dq[3:2]); end
  endtask
  task automatic test_rdid();
    int n = 0;
    bit ok;
    release_rst();
    while (S !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n > 10) begin errors++; $display("FAIL first_s_fall clocks=%0d required<=10", n); end
    wait_nf(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rdid_timeout frames=%0d required=1", nf); end
    checks++; if (fb[0][0] !== 8'h9F) begin errors++; $display("FAIL rdid_opcode got=%h required=9f", fb[0][0]); end
    checks++; if (fp[0] != 32) begin errors++; $display("FAIL rdid_pulses got=%0d required=32", fp[0]); end
  endtask
  task automatic test_wren();
    bit ok;
    wait_nf(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wren_timeout frames=%0d required=2", nf); end
    checks++; if (fop[1] !== 8'h06) begin errors++; $display("FAIL wren_opcode got=%h required=06", fop[1]); end
    checks++; if (fp[1] != 8) begin errors++; $display("FAIL wren_pulses got=%0d required=8", fp[1]); end
  endtask
  task automatic test_pp();
    bit ok;
    logic [7:0] exp;
    wait_nf(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pp_timeout frames=%0d required=3", nf); end
    checks++; if (fp[2] != 160) begin errors++; $display("FAIL pp_pulses got=%0d required=160", fp[2]); end
    for (int i = 0; i < 20; i++) begin
      exp = i == 0 ? 8'h02 : i < 4 ? 8'h00 : 8'((i - 4) * 17 + 90);
      checks++; if (fb[2][i] !== exp) begin errors++; $display("FAIL pp_byte%0d got=%h required=%h", i, fb[2][i], exp); end
    end
    checks++; if (fb[2][5] !== 8'h6B || fb[2][19] !== 8'h59) begin errors++; $display("FAIL pp_pattern got=%h,%h required=6b,59", fb[2][5], fb[2][19]); end
  endtask
  task automatic test_done();
    bit ok;
    wait_led(ok);
    checks++; if (!ok) begin errors++; $display("FAIL done_timeout led=%b required=x1", LED); end
    checks++; if (LED !== 2'b11) begin errors++; $display("FAIL done_led got=%b required=11", LED); end
    checks++; if (nf != 5) begin errors++; $display("FAIL done_frames got=%0d required=5", nf); end
    checks++; if (fop[3] !== 8'h05 || fp[3] != 32) begin errors++; $display("FAIL poll_frame op=%h pulses=%0d required=05,32", fop[3], fp[3]); end
    checks++; if (fop[4] !== 8'h03 || fp[4] != 160) begin errors++; $display("FAIL read_frame op=%h pulses=%0d required=03,160", fop[4], fp[4]); end
    checks++; if (mem[0] !== 8'h5A || mem[2] !== 8'h7C || mem[15] !== 8'h59 || mem[16] !== 8'hFF)
      begin errors++; $display("FAIL flash_content got=%h %h %h %h required=5a 7c 59 ff", mem[0], mem[2], mem[15], mem[16]); end
    repeat (200) @(negedge clk);
    checks++; if (LED !== 2'b11 || S !== 1'b1 || nf != 5) begin errors++; $display("FAIL done_hold led=%b s=%b frames=%0d required=11,1,5", LED, S, nf); end
  endtask
  task automatic test_bad_id();
    bit ok;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    model_reset(24'hEFBA18);
    release_rst();
    wait_led(ok);
    checks++; if (!ok) begin errors++; $display("FAIL badid_timeout led=%b required=x1", LED); end
    checks++; if (LED !== 2'b01) begin errors++; $display("FAIL badid_led got=%b required=01", LED); end
    repeat (300) @(negedge clk);
    checks++; if (nf != 1 || LED !== 2'b01) begin errors++; $display("FAIL badid_hold frames=%0d led=%b required=1,01", nf, LED); end
  endtask
  task automatic test_back_to_back();
    bit ok;
    int t = 0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    model_reset(24'h20BA18);
    release_rst();
    while (!(nf == 2 && open && cur_p >= 60) && t < 20000) begin @(negedge clk); t++; end
    checks++; if (t >= 20000) begin errors++; $display("FAIL midpp_timeout frames=%0d pulses=%0d required=2,>=60", nf, cur_p); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (S !== 1'b1 || LED !== 2'b00) begin errors++; $display("FAIL midpp_abort s=%b led=%b required=1,00", S, LED); end
    repeat (3) @(negedge clk);
    checks++; if (nf != 3 || fop[2] !== 8'h02) begin errors++; $display("FAIL midpp_frame frames=%0d op=%h required=3,02", nf, fop[2]); end
    rst = 1'b0;
    wait_nf(4, ok);
    checks++; if (!ok || fb[3][0] !== 8'h9F) begin errors++; $display("FAIL restart_rdid op=%h required=9f", fb[3][0]); end
    wait_led(ok);
    checks++; if (LED !== 2'b11 || nf != 8) begin errors++; $display("FAIL restart_done led=%b frames=%0d required=11,8", LED, nf); end
  endtask
  initial begin
    test_reset();
    test_rdid();
    test_wren();
    test_pp();
    test_done();
    test_bad_id();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
